// File: rtl/delay_sweep_sequencer_if.sv
// delay_sweep_sequencer_if: control, config and status bundle of the delay sweep sequencer
// master: drives start/abort and the sweep config, observes delay/status
// slave : the sequencer itself
interface delay_sweep_sequencer_if #(parameter int W = 16);
    logic         start;
    logic         abort;
    logic [W-1:0] del_start;
    logic [W-1:0] del_step;
    logic [W-1:0] n_points;
    logic [W-1:0] n_avg;
    logic [W-1:0] del_out;
    logic [W-1:0] point_idx;
    logic         busy;
    logic         point_done;
    logic         done;
    modport master (
        output start, abort, del_start, del_step, n_points, n_avg,
        input  del_out, point_idx, busy, point_done, done
    );
    modport slave (
        input  start, abort, del_start, del_step, n_points, n_avg,
        output del_out, point_idx, busy, point_done, done
    );
endinterface

// File: rtl/delay_sweep_sequencer.sv
// delay_sweep_sequencer: steps the pulse generator's channel-1 delay through a linear sweep
// clk, rst : 12 MHz clock, synchronous active-high reset
// sync_in  : asynchronous scope-trigger from the pulse generator, one falling edge per period
// bus      : slave side of delay_sweep_sequencer_if (start/abort, sweep config, delay and status)
module delay_sweep_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int W = 16
) (
    input logic clk,
    input logic rst,
    input logic sync_in,
    delay_sweep_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, FINISH} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic sync_prev, fall;
    logic [W-1:0] cfg_start, cfg_step, cfg_npts, cfg_navg, shots;
    logic [W-1:0] del_n, idx_n, shots_n, shots_inc, avg_target;
    logic [W:0] sum;
    logic pd_n, done_n, capture;
    assign bus.busy = (state != IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff        <= '0;
            sync_prev      <= 1'b0;
            fall           <= 1'b0;
            state          <= IDLE;
            bus.del_out    <= '0;
            bus.point_idx  <= '0;
            bus.point_done <= 1'b0;
            bus.done       <= 1'b0;
            shots          <= '0;
            cfg_start      <= '0;
            cfg_step       <= '0;
            cfg_npts       <= '0;
            cfg_navg       <= '0;
        end else begin
            sync_ff        <= {sync_ff[SYNC_STAGES-2:0], sync_in};
            sync_prev      <= sync_ff[SYNC_STAGES-1];
            // registered edge detect: fall lands SYNC_STAGES+1 cycles after the real edge
            fall           <= sync_prev & ~sync_ff[SYNC_STAGES-1];
            state          <= state_n;
            bus.del_out    <= del_n;
            bus.point_idx  <= idx_n;
            bus.point_done <= pd_n;
            bus.done       <= done_n;
            shots          <= shots_n;
            if (capture) begin
                cfg_start <= bus.del_start;
                cfg_step  <= bus.del_step;
                cfg_npts  <= bus.n_points;
                cfg_navg  <= bus.n_avg;
            end
        end
    end
    always_comb begin
        sum        = {1'b0, bus.del_out} + {1'b0, cfg_step};
        shots_inc  = shots + 1'b1;
        avg_target = (cfg_navg == '0) ? W'(1) : cfg_navg;
        state_n    = state;
        del_n      = bus.del_out;
        idx_n      = bus.point_idx;
        shots_n    = shots;
        pd_n       = 1'b0;
        done_n     = 1'b0;
        capture    = 1'b0;
        if (state != IDLE && bus.abort) state_n = IDLE;
        else case (state)
            IDLE: if (bus.start && !bus.abort) begin
                if (bus.n_points == '0) done_n = 1'b1;
                else begin
                    capture = 1'b1;
                    state_n = ARM;
                end
            end
            // the period already in progress at start is skipped: first fall only loads the delay
            ARM: if (fall) begin
                del_n   = cfg_start;
                idx_n   = '0;
                shots_n = '0;
                state_n = RUN;
            end
            RUN: if (fall) begin
                if (shots_inc == avg_target) begin
                    pd_n    = 1'b1;
                    shots_n = '0;
                    if (bus.point_idx == cfg_npts - 1'b1) state_n = FINISH;
                    else begin
                        idx_n = bus.point_idx + 1'b1;
                        del_n = sum[W] ? '1 : sum[W-1:0];
                    end
                end else shots_n = shots_inc;
            end
            FINISH: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/delay_sweep_sequencer.md
Name: delay_sweep_sequencer

Overview:
- Sits directly upstream of the pulse-timing generator on the 12 MHz clk domain.
- Drives its channel-1 delay input, stepping it through a linear sweep of n_points values.
- Holds each value for n_avg complete repetition periods, as delimited by the generator's scope-trigger (sync) output fed back in.
- Parameter changes occur only just after a sync falling edge, so every counted period is generated with a single, stable delay.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sync_in (minimum 2)
- W, 16, width of delay, step and count fields

Ports:
- clk  in  1  12 MHz system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to begin a sweep; ignored while busy
- abort  in  1  single-cycle request to stop; takes priority over start
- del_start  in  W  first delay value (200 MHz cycles)
- del_step  in  W  increment per point
- n_points  in  W  number of sweep points
- n_avg  in  W  periods per point; 0 is treated as 1
- sync_in  in  1  sync pulse from the pulse generator (clk_pll domain, asynchronous here)
- del_out  out  W  delay value presented to the pulse generator
- point_idx  out  W  index of the current point
- busy  out  1  high from accepted start until DONE/abort
- point_done  out  1  1-cycle strobe when a point's n_avg periods are complete
- done  out  1  1-cycle strobe at sweep completion

Behaviour:
- Reset values: del_out=0, point_idx=0, busy=0, point_done=0, done=0, FSM=IDLE, shot counter=0, synchronizer flops=0.
- sync_in path:
  - Passes through SYNC_STAGES flops, then one edge-detect register.
  - fall = prev & ~cur; fall is asserted SYNC_STAGES+1 clk cycles after the real falling edge.
  - sync_in high/low pulses must each last ≥3 clk periods (caller's responsibility).
- Inputs del_start, del_step, n_points and n_avg are captured into internal registers on the accepted start. Later changes are ignored until the next start.
- FSM states:
  - IDLE: busy=0. On start, with abort=0:
    - If n_points=0: emit done the next cycle and stay IDLE, busy never asserted.
    - Otherwise: capture inputs, busy=1, go to ARM.
  - ARM: wait for fall. On fall: del_out<=del_start, point_idx<=0, shot counter<=0, go to RUN. The period in progress at start is never counted.
  - RUN: each fall increments the shot counter. When the counter reaches n_avg (after that fall):
    - pulse point_done for 1 cycle;
    - if point_idx = n_points-1, go to FINISH;
    - otherwise point_idx+1, del_out<=del_out+del_step, shot counter<=0, stay in RUN.
    - del_out therefore changes exactly 1 cycle after the qualifying fall.
  - FINISH: done=1 for one cycle, busy<=0, go to IDLE. del_out holds the last value.
- Arithmetic:
  - del_out+del_step is computed at W+1 bits and saturates at 2^W-1.
  - Once saturated, del_out stays at 2^W-1 for the remaining points; point counting continues.
- abort: in any non-IDLE state, go to IDLE next cycle with busy=0 and no done or point_done. del_out and point_idx hold their values.
- start while busy: ignored.
- start and abort in the same cycle: abort wins; in IDLE both are ignored.
- fall in the same cycle as abort: abort wins; no point_done.
- rst mid-sweep: all reset values apply on the next clk edge, including del_out=0.
- Counters:
  - The shot counter compares at W bits. n_avg=65535 is legal.
  - point_idx never exceeds n_points-1.

Test Plan:
- del_start=100, del_step=20, n_points=3, n_avg=2; sync period 1000 clk, high 50 clk; start pulsed:
  - the first fall loads del_out=100;
  - del_out becomes 120 after 2 further falls, then 140 after 2 more;
  - point_done fires 3 times; done fires 1 cycle after the 3rd point_done;
  - busy falls with done.
- Timing check on the same setup: del_out changes exactly SYNC_STAGES+2 clk cycles after the sync_in falling edge, and never while sync_in is high.
- n_points=0 -> done 1 cycle after start, busy stays 0.
- n_avg=0 -> behaves as n_avg=1.
- del_start=65500, del_step=30, n_points=3 -> del_out sequence is 65500, 65530, 65535 (saturated).
- Abort during the second point -> busy=0 the next cycle, no done, del_out holds 120; a subsequent start re-arms and reloads 100.
- rst asserted mid-RUN -> all outputs zero the next cycle.
- start and abort in the same cycle while IDLE -> nothing happens.
